stoch_decode_mat: RTL and testbench
===================================

Name: stoch_decode_mat

Overview:
- Downstream consumer of the stochastic saturating matrix subtractor.
- Converts a row-major vector of NUM_ROWS*NUM_COLS stochastic bitstreams into binary estimates by counting ones per element over a fixed window of 2^WINDOW_LOG2 clocks.
- Start/valid handshake; results held in output registers until the next window completes.
- Used at the stochastic-to-binary boundary of matrix datapaths.

Parameters:
- NUM_ROWS, 2, matrix rows.
- NUM_COLS, 2, matrix columns.
- WINDOW_LOG2, 8, log2 of window length L = 2^WINDOW_LOG2 samples; legal range 1..16.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  asynchronous active-low reset.
- start  input  1  request to begin a window; honoured only in IDLE.
- X  input  NUM_ROWS*NUM_COLS  stochastic bitstreams, row-major; element (i,j) at bit i*NUM_COLS+j.
- Y  output  NUM_ROWS*NUM_COLS*(WINDOW_LOG2+1)  per-element ones count; element k occupies bits [k*(WINDOW_LOG2+1) +: WINDOW_LOG2+1].
- valid  output  1  single-cycle pulse: Y was just updated.
- busy  output  1  high while a window is being counted.

Behaviour:
- Reset (nRST low, async):
  - state=IDLE; window counter=0; all accumulators=0.
  - Y=0, valid=0, busy=0.
  - Deassertion is synchronised by the surrounding design; the block needs no internal synchroniser.
- State machine: two states, IDLE and COUNT.
- IDLE:
  - busy=0.
  - On an edge with start=1: clear all accumulators and the window counter; go to COUNT.
  - X on the start edge is not counted.
- COUNT:
  - busy=1.
  - On every edge, each accumulator adds its X bit; the window counter increments.
  - Exactly L samples are taken, on edges t+1..t+L, where t is the accepting start edge.
  - On edge t+L (window counter = L-1):
    - Y <= accumulator + final X bit, all elements simultaneously.
    - valid <= 1; state <= IDLE; window counter <= 0.
- valid:
  - Registered; high for exactly the one cycle following edge t+L; 0 otherwise.
  - Latency from start edge to valid high: L clocks.
- Y:
  - Changes only at window completion or reset; holds its value otherwise, including throughout the next window.
- Width:
  - Accumulators and Y fields are WINDOW_LOG2+1 bits, so the all-ones count L is representable. No saturation or wrap can occur.
  - Window counter is WINDOW_LOG2 bits.
  - Value estimate = Y/L, interpreted by the consumer. For bipolar encoding the consumer computes 2Y-L; this block has no encoding knowledge.
- Start handling:
  - start=1 while busy is ignored: no restart, no queuing.
  - start held high continuously restarts a window on the edge after each completion. Windows therefore repeat every L+1 clocks.
  - start=1 in the cycle valid is high is accepted, because state is already IDLE.
- Reset mid-window: the partial count is discarded; Y returns to 0; no valid pulse is produced.
- X is treated as synchronous to CLK; no input registering beyond the accumulators.

Test Plan (WINDOW_LOG2=4, L=16, NUM_ROWS=NUM_COLS=2):
- All-ones / all-zeros:
  - Stimulus: X=4'b0101 constant; pulse start for 1 cycle.
  - Required: busy high 16 cycles; valid pulses exactly 16 clocks after the start edge.
  - Required: Y fields = {k3=0, k2=16, k1=0, k0=16}; busy falls with the valid pulse.
- Fractional stream:
  - Stimulus: element 0 driven 1 on alternate samples; element 1 driven 1 on every 4th sample; elements 2,3 fixed 0.
  - Required: Y0=8, Y1=4, Y2=Y3=0.
  - Required: X high on the start edge itself does not change the count.
- Start while busy:
  - Stimulus: start; pulse start again at sample 5.
  - Required: single valid at 16 clocks after the first start; Y unaffected by the second pulse.
- Back-to-back:
  - Stimulus: hold start=1 with X=4'b1111 for 40 clocks.
  - Required: valid pulses at 16 and 33 clocks after the first start edge, each with all Y fields = 16.
  - Required: busy low for exactly one cycle between windows.
- Reset mid-window:
  - Stimulus: complete one window giving Y0=16; start a second window; assert nRST low asynchronously (between edges) at sample 7.
  - Required: Y=0, busy=0, valid=0 immediately.
  - Required: after release with start=0, outputs stay 0 and no valid pulse appears.
- Hold behaviour:
  - Stimulus: after a completed window with Y0=16, start a new window with X=0.
  - Required: Y0 stays 16 throughout the new window; it updates to 0 only at the new valid pulse.

Source files
------------

// File: rtl/stoch_decode_mat.sv
// Stochastic-to-binary decoder: counts ones per element of a row-major bitstream
// vector over a fixed window of 2^WINDOW_LOG2 clocks, with a start/valid handshake.
module stoch_decode_mat #(
  parameter int unsigned NUM_ROWS    = 2,
  parameter int unsigned NUM_COLS    = 2,
  parameter int unsigned WINDOW_LOG2 = 8
) (
  input  logic                                          CLK,
  input  logic                                          nRST,
  input  logic                                          start,
  input  logic [NUM_ROWS*NUM_COLS-1:0]                  X,
  output logic [NUM_ROWS*NUM_COLS*(WINDOW_LOG2+1)-1:0]  Y,
  output logic                                          valid,
  output logic                                          busy
);

  localparam int unsigned N = NUM_ROWS * NUM_COLS;
  localparam int unsigned W = WINDOW_LOG2 + 1;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t                 state;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [W-1:0]           acc [N];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      win_cnt <= '0;
      Y       <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      for (int unsigned k = 0; k < N; k++) acc[k] <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          // X on the accepting edge is deliberately not sampled.
          if (start) begin
            state   <= COUNT;
            busy    <= 1'b1;
            win_cnt <= '0;
            for (int unsigned k = 0; k < N; k++) acc[k] <= '0;
          end
        end
        COUNT: begin
          win_cnt <= win_cnt + WINDOW_LOG2'(1);
          for (int unsigned k = 0; k < N; k++) acc[k] <= acc[k] + W'(X[k]);
          // Last sample of the window is folded straight into Y.
          if (win_cnt == '1) begin
            for (int unsigned k = 0; k < N; k++) Y[k*W +: W] <= acc[k] + W'(X[k]);
            valid   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
            win_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stoch_decode_mat.sv
// Bench for stoch_decode_mat (2x2, WINDOW_LOG2=4): queue-based sample model
// compared every cycle, plus directed windows with hand-computed results.
module tb_stoch_decode_mat;

  localparam int WL = 4;
  localparam int L  = 16;
  localparam int W  = WL + 1;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          start;
  logic [3:0]    X;
  logic [4*W-1:0] Y;
  logic          valid;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  stoch_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_LOG2(WL)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .X(X), .Y(Y), .valid(valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a window is the list of the next L samples after an accepted start;
  // the result is the per-element popcount of that list.
  bit             m_active = 1'b0;
  bit             m_valid  = 1'b0;
  logic [4*W-1:0] m_Y      = '0;
  logic [3:0]     samples[$];

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_active = 1'b0;
      m_valid  = 1'b0;
      m_Y      = '0;
      samples.delete();
    end else begin
      m_valid = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          samples.delete();
        end
      end else begin
        samples.push_back(X);
        if (samples.size() == L) begin
          for (int k = 0; k < 4; k++) begin
            int cnt;
            cnt = 0;
            foreach (samples[i]) cnt += samples[i][k];
            m_Y[k*W +: W] = W'(cnt);
          end
          m_valid  = 1'b1;
          m_active = 1'b0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("valid", valid, m_valid);
    chk("busy", busy, m_active);
    chk("Y", Y, m_Y);
  end

  function automatic logic [3:0] gen_x(input int mode, input int s);
    case (mode)
      0:       return 4'b0101;
      1:       return {2'b00, (s % 4 == 0), (s % 2 == 1)};
      2:       return 4'b0000;
      default: return 4'($urandom);
    endcase
  endfunction

  // Runs one window from IDLE. restart_at>=2 pulses start on that sample's edge.
  task automatic run_window(input int mode, input int restart_at,
                            output int lat, output int bcnt, output logic [W-1:0] y0_mid);
    @(negedge CLK);
    start = 1'b1;
    X     = (mode == 1) ? 4'hF : gen_x(mode, 0);
    @(negedge CLK);
    start  = 1'b0;
    lat    = -1;
    bcnt   = busy ? 1 : 0;
    y0_mid = '0;
    X      = gen_x(mode, 1);
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      start = (n + 1 == restart_at);
      X     = gen_x(mode, n + 1);
      if (n == 8) y0_mid = Y[W-1:0];
      if (valid) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
    end
    start = 1'b0;
    if (lat < 0) chk("valid_timeout", 0, 1);
  endtask

  int             lat, bcnt, vcnt, lowcnt;
  int             vpos[$];
  logic [W-1:0]   y0m;

  initial begin
    nRST  = 1'b0;
    start = 1'b0;
    X     = '0;
    repeat (3) @(negedge CLK);
    chk("reset_Y", Y, 0);
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Constant 0101 stream.
    run_window(0, 0, lat, bcnt, y0m);
    chk("t1_latency", lat, 16);
    chk("t1_busy_cycles", bcnt, 16);
    chk("t1_busy_at_valid", busy, 0);
    chk("t1_Y", Y, {5'd0, 5'd16, 5'd0, 5'd16});

    // Fractional streams, X=F on the start edge.
    run_window(1, 0, lat, bcnt, y0m);
    chk("t2_latency", lat, 16);
    chk("t2_Y", Y, {5'd0, 5'd0, 5'd4, 5'd8});

    // Second start at sample 5 is ignored.
    run_window(0, 5, lat, bcnt, y0m);
    chk("t3_latency", lat, 16);
    chk("t3_Y", Y, {5'd0, 5'd16, 5'd0, 5'd16});
    vcnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (valid) vcnt++;
    end
    chk("t3_extra_valid", vcnt, 0);

    // Back-to-back with start held high.
    @(negedge CLK);
    start = 1'b1;
    X     = 4'hF;
    @(negedge CLK);
    lowcnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (valid) begin
        vpos.push_back(n);
        chk("t4_Y", Y, {5'd16, 5'd16, 5'd16, 5'd16});
      end
      if (n <= 32 && !busy) lowcnt++;
    end
    start = 1'b0;
    chk("t4_valid_count", vpos.size(), 2);
    if (vpos.size() >= 2) begin
      chk("t4_first_valid", vpos[0], 16);
      chk("t4_second_valid", vpos[1], 33);
    end
    chk("t4_busy_low_gap", lowcnt, 1);
    repeat (20) @(negedge CLK);

    // Hold behaviour: Y keeps the previous result during a zero window.
    run_window(0, 0, lat, bcnt, y0m);
    chk("t6_prev_Y0", Y[W-1:0], 16);
    run_window(2, 0, lat, bcnt, y0m);
    chk("t6_mid_Y0", y0m, 16);
    chk("t6_new_Y", Y, 0);

    // Reset mid-window after a completed window.
    run_window(0, 0, lat, bcnt, y0m);
    @(negedge CLK);
    start = 1'b1;
    X     = 4'hF;
    @(negedge CLK);
    start = 1'b0;
    repeat (6) @(negedge CLK);
    @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("t5_rst_Y", Y, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", valid, 0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    vcnt = 0;
    repeat (24) begin
      @(negedge CLK);
      if (valid || busy || Y != 0) vcnt++;
    end
    chk("t5_quiet_after_reset", vcnt, 0);

    // Randomised windows with random gaps and ignored restarts.
    for (int w = 0; w < 8; w++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      run_window(3, int'($urandom_range(2, 15)), lat, bcnt, y0m);
      chk("rand_latency", lat, 16);
    end

    // Random start/X activity driven cycle by cycle.
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      start = ($urandom_range(0, 7) == 0);
      X     = 4'($urandom);
    end
    start = 1'b0;
    repeat (20) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
